// File: rtl/can_pkg.sv
// CAN receive-path types shared by the filter FIFO and the TX queue.
// Frame layout matches the controller receive word bit-for-bit.
package can_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;

  typedef struct packed {
    logic                  rtr;
    logic [CAN_DLC_W-1:0]  dlc;
    logic [CAN_ID_W-1:0]   id;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

endpackage

// File: rtl/can_sync_fifo.sv
// Single-clock show-ahead FIFO with extra-MSB pointers.
// A push into a full FIFO is taken only when a pop frees the slot.
module can_sync_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/can_rx_filter_fifo.sv
// CAN RX acceptance filter, one stage register and a frame FIFO.
// Counts accepted frames dropped while the FIFO stays full.
module can_rx_filter_fifo
  import can_pkg::*;
#(
  parameter int NFILT = 4,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [79:0]               rx_data_i,
  input  logic                      rx_dvalid_i,
  input  logic [NFILT-1:0]          filt_en_i,
  input  logic [NFILT*CAN_ID_W-1:0] filt_code_i,
  input  logic [NFILT*CAN_ID_W-1:0] filt_mask_i,
  output logic [CAN_ID_W-1:0]       out_id_o,
  output logic [CAN_DLC_W-1:0]      out_dlc_o,
  output logic                      out_rtr_o,
  output logic [CAN_DATA_W-1:0]     out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LW-1:0]             fifo_level_o,
  output logic [CNTW-1:0]           overflow_cnt_o,
  input  logic                      overflow_clr_i
);

  can_frame_t rx_frame;
  can_frame_t s1_frame;
  can_frame_t head;
  can_frame_t head_q;
  logic       rx_match;
  logic       s1_valid;
  logic       s1_match;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;

  assign rx_frame = can_frame_t'(rx_data_i);

  // No enabled slot means promiscuous mode.
  always_comb begin
    rx_match = 1'b0;
    for (int k = 0; k < NFILT; k++) begin
      if (filt_en_i[k] &&
          (((rx_frame.id ^ filt_code_i[k*CAN_ID_W +: CAN_ID_W]) &
            filt_mask_i[k*CAN_ID_W +: CAN_ID_W]) == '0))
        rx_match = 1'b1;
    end
    if (filt_en_i == '0) rx_match = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_match <= 1'b0;
      s1_frame <= '0;
    end else begin
      s1_valid <= rx_dvalid_i;
      if (rx_dvalid_i) begin
        s1_frame <= rx_frame;
        s1_match <= rx_match;
      end
    end
  end

  assign push = s1_valid & s1_match;
  assign pop  = out_valid_o & out_ready_i;
  assign drop = push & full & ~pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_cnt_o <= '0;
    end else if (overflow_clr_i) begin
      overflow_cnt_o <= '0;
    end else if (drop && !(&overflow_cnt_o)) begin
      overflow_cnt_o <= overflow_cnt_o + 1'b1;
    end
  end

  can_sync_fifo #(
    .WIDTH($bits(can_frame_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (push),
    .push_data(s1_frame),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level_o)
  );

  // Payload reads as zero whenever nothing is presented.
  assign head_q      = empty ? '0 : head;
  assign out_valid_o = ~empty;
  assign out_id_o    = head_q.id;
  assign out_dlc_o   = head_q.dlc;
  assign out_rtr_o   = head_q.rtr;
  assign out_data_o  = head_q.data;

endmodule
